// File: rtl/cdb_pkg.sv
// Shared CDB types and the modulo ROB-age helper used by the arbiter and the RS flush.
package cdb_pkg;

    localparam int CDB_PREG_W = 7;
    localparam int CDB_ROB_W  = 4;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  live;
        logic [CDB_PREG_W-1:0] prd;
        logic [CDB_ROB_W-1:0]  rob_tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    // Younger means 1 <= (tag - ref_tag) mod 2**W < 2**(W-1); the branch itself (d==0) is not younger.
    function automatic logic rob_is_younger(input logic [CDB_ROB_W-1:0] tag,
                                            input logic [CDB_ROB_W-1:0] ref_tag);
        logic [CDB_ROB_W-1:0] d;
        d = tag - ref_tag;
        return (d != '0) && !d[CDB_ROB_W-1];
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-EU result FIFO: circular buffer with a per-entry live bit cleared by a flush.
module eu_result_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  cdb_entry_t           wr_entry,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [CDB_ROB_W-1:0] flush_tag,
    output cdb_entry_t           head,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    cdb_entry_t     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Kill is applied to every slot; a write in the same cycle lands on a free slot and carries its own live bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && rob_is_younger(mem[i].rob_tag, flush_tag)) mem[i].live <= 1'b0;
        end
        if (push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-EU result FIFOs, round-robin grant, registered broadcast.
// Optional same-cycle bypass into the output register when CDB_ARBITER_BYPASS_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_EU     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PREG_WIDTH = CDB_PREG_W,
    parameter int ROB_WIDTH  = CDB_ROB_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_EU-1:0]          i_eu_valid,
    input  logic [NUM_EU*PREG_WIDTH-1:0] i_eu_prd,
    input  logic [NUM_EU*ROB_WIDTH-1:0]  i_eu_rob_tag,
    input  logic [NUM_EU*32-1:0]       i_eu_data,
    output logic [NUM_EU-1:0]          o_eu_ready,
    output logic                       o_cdb_valid,
    output logic [PREG_WIDTH-1:0]      o_cdb_prd,
    output logic [ROB_WIDTH-1:0]       o_cdb_rob_tag,
    output logic [31:0]                o_cdb_data,
    input  logic                       branch_mispredict,
    input  logic [ROB_WIDTH-1:0]       mispredict_rob_tag
);

    localparam int PW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

    cdb_entry_t        in_entry [NUM_EU];
    cdb_entry_t        head     [NUM_EU];
    cdb_entry_t        grant_entry;
    logic [NUM_EU-1:0] empty, full, transfer, push, pop;
    logic [NUM_EU-1:0] head_live, byp_cand, cand, grant_vec;
    logic [PW-1:0]     ptr, grant_idx;
    logic              grant_any;

    assign o_eu_ready = ~full;

    always_comb begin
        int idx;
        idx         = 0;
        transfer    = i_eu_valid & ~full;
        head_live   = '0;
        byp_cand    = '0;
        grant_vec   = '0;
        push        = '0;
        pop         = '0;
        grant_any   = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_EU; k++) begin
            in_entry[k] = '{live:    !(branch_mispredict &&
                                       rob_is_younger(i_eu_rob_tag[k*ROB_WIDTH +: ROB_WIDTH], mispredict_rob_tag)),
                            prd:     i_eu_prd[k*PREG_WIDTH +: PREG_WIDTH],
                            rob_tag: i_eu_rob_tag[k*ROB_WIDTH +: ROB_WIDTH],
                            data:    i_eu_data[k*32 +: 32]};
            // A head being killed this cycle must already lose arbitration.
            head_live[k] = !empty[k] && head[k].live &&
                           !(branch_mispredict && rob_is_younger(head[k].rob_tag, mispredict_rob_tag));
`ifdef CDB_ARBITER_BYPASS_EN
            byp_cand[k]  = empty[k] && transfer[k] && in_entry[k].live;
`endif
        end
        cand = head_live | byp_cand;

        for (int i = 1; i <= NUM_EU; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_EU) idx = idx - NUM_EU;
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end

        grant_entry = head[grant_idx];
`ifdef CDB_ARBITER_BYPASS_EN
        if (byp_cand[grant_idx]) grant_entry = in_entry[grant_idx];
`endif

        for (int k = 0; k < NUM_EU; k++) begin
            grant_vec[k] = grant_any && (grant_idx == PW'(k));
            // Dead heads drain silently; live heads leave only on a grant.
            pop[k]  = (!empty[k] && !head[k].live) || (grant_vec[k] && head_live[k]);
            push[k] = transfer[k] && !(grant_vec[k] && byp_cand[k]);
        end
    end

    for (genvar k = 0; k < NUM_EU; k++) begin : g_fifo
        eu_result_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[k]),
            .wr_entry  (in_entry[k]),
            .pop       (pop[k]),
            .flush     (branch_mispredict),
            .flush_tag (mispredict_rob_tag),
            .head      (head[k]),
            .empty     (empty[k]),
            .full      (full[k])
        );
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr           <= PW'(NUM_EU - 1);
            o_cdb_valid   <= 1'b0;
            o_cdb_prd     <= '0;
            o_cdb_rob_tag <= '0;
            o_cdb_data    <= '0;
        end else if (grant_any) begin
            ptr           <= grant_idx;
            o_cdb_valid   <= 1'b1;
            o_cdb_prd     <= grant_entry.prd;
            o_cdb_rob_tag <= grant_entry.rob_tag;
            o_cdb_data    <= grant_entry.data;
        end else begin
            o_cdb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations adapt to CDB_ARBITER_BYPASS_EN.
module tb_cdb_arbiter;

`ifdef CDB_ARBITER_BYPASS_EN
    localparam int LAT = 1;
    localparam logic [2:0] FILL_READY = 3'b011;
`else
    localparam int LAT = 2;
    localparam logic [2:0] FILL_READY = 3'b001;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  i_eu_valid = '0;
    logic [20:0] i_eu_prd = '0;
    logic [11:0] i_eu_rob_tag = '0;
    logic [95:0] i_eu_data = '0;
    logic [2:0]  o_eu_ready;
    logic        o_cdb_valid;
    logic [6:0]  o_cdb_prd;
    logic [3:0]  o_cdb_rob_tag;
    logic [31:0] o_cdb_data;
    logic        branch_mispredict = 1'b0;
    logic [3:0]  mispredict_rob_tag = '0;

    int checks = 0;
    int passes = 0;
    int seen [128];
    bit fill_mode = 1'b0;
    int nxt [3];

    cdb_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .i_eu_valid         (i_eu_valid),
        .i_eu_prd           (i_eu_prd),
        .i_eu_rob_tag       (i_eu_rob_tag),
        .i_eu_data          (i_eu_data),
        .o_eu_ready         (o_eu_ready),
        .o_cdb_valid        (o_cdb_valid),
        .o_cdb_prd          (o_cdb_prd),
        .o_cdb_rob_tag      (o_cdb_rob_tag),
        .o_cdb_data         (o_cdb_data),
        .branch_mispredict  (branch_mispredict),
        .mispredict_rob_tag (mispredict_rob_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        int k;
        @(posedge clk);
        #1;
        if (o_cdb_valid === 1'b1) begin
            seen[o_cdb_prd]++;
            if (fill_mode) begin
                k = int'(o_cdb_prd[6:4]);
                check("fill_eu_index", 64'(k < 3), 64'd1);
                if (k < 3) begin
                    check("fill_order", 64'(o_cdb_prd[3:0]), 64'(nxt[k]));
                    nxt[k]++;
                end
            end
        end
    endtask

    task automatic set_eu(input int k, input logic [6:0] prd, input logic [3:0] tag, input logic [31:0] data);
        i_eu_prd[k*7 +: 7]     = prd;
        i_eu_rob_tag[k*4 +: 4] = tag;
        i_eu_data[k*32 +: 32]  = data;
    endtask

    task automatic clear_seen();
        foreach (seen[i]) seen[i] = 0;
    endtask

    task automatic do_reset();
        i_eu_valid = '0;
        branch_mispredict = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int e;
        clear_seen();

        // Reset held for three cycles
        repeat (3) step();
        check("rst_valid", 64'(o_cdb_valid), 64'd0);
        check("rst_ready", 64'(o_eu_ready), 64'h7);
        check("rst_prd", 64'(o_cdb_prd), 64'd0);
        check("rst_data", 64'(o_cdb_data), 64'd0);
        reset = 1'b1;
        step();
        check("post_rst_valid", 64'(o_cdb_valid), 64'd0);

        // Three EUs in one cycle: round-robin from EU0
        set_eu(0, 7'd5, 4'd1, 32'h1111);
        set_eu(1, 7'd6, 4'd2, 32'h2222);
        set_eu(2, 7'd7, 4'd3, 32'h3333);
        i_eu_valid = 3'b111;
        for (int s = 1; s <= LAT + 3; s++) begin
            step();
            i_eu_valid = '0;
            e = s - LAT;
            if (e >= 0 && e < 3) begin
                check("rr_valid", 64'(o_cdb_valid), 64'd1);
                check("rr_prd", 64'(o_cdb_prd), 64'(5 + e));
                if (e == 0) begin
                    check("rr_tag", 64'(o_cdb_rob_tag), 64'd1);
                    check("rr_data", 64'(o_cdb_data), 64'h1111);
                end
            end else begin
                check("rr_idle", 64'(o_cdb_valid), 64'd0);
            end
        end

        // EU1 back-to-back, including preg 0
        clear_seen();
        for (int s = 1; s <= 4 + LAT; s++) begin
            if (s <= 4) begin
                i_eu_valid = 3'b010;
                set_eu(1, 7'(s - 1), 4'(s), 32'(s * 3));
            end else begin
                i_eu_valid = '0;
            end
            step();
            check("b2b_ready1", 64'(o_eu_ready[1]), 64'd1);
            e = s - LAT;
            if (e >= 0 && e < 4) begin
                check("b2b_valid", 64'(o_cdb_valid), 64'd1);
                check("b2b_prd", 64'(o_cdb_prd), 64'(e));
            end else begin
                check("b2b_idle", 64'(o_cdb_valid), 64'd0);
            end
        end
        i_eu_valid = '0;
        repeat (3) step();
        check("b2b_count", 64'(seen[0] + seen[1] + seen[2] + seen[3]), 64'd4);

        // All EUs streaming: FIFOs fill, per-EU order holds
        do_reset();
        for (int k = 0; k < 3; k++) nxt[k] = 0;
        fill_mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_eu_valid = 3'b111;
            for (int k = 0; k < 3; k++) set_eu(k, 7'(k * 16 + c), 4'd0, 32'(c));
            step();
        end
        i_eu_valid = '0;
        check("fill_ready", 64'(o_eu_ready), 64'(FILL_READY));
        repeat (20) step();
        fill_mode = 1'b0;
        for (int k = 0; k < 3; k++) check("fill_total", 64'(nxt[k]), 64'd5);
        check("fill_drained_ready", 64'(o_eu_ready), 64'h7);

        // Flush at tag 3: EU0 tags 4 and 5 die, tag 3 and older others survive
        do_reset();
        clear_seen();
        i_eu_valid = 3'b111;
        set_eu(0, 7'd10, 4'd3, 32'hA0);
        set_eu(1, 7'd20, 4'd0, 32'hB0);
        set_eu(2, 7'd30, 4'd0, 32'hC0);
        step();
        set_eu(0, 7'd11, 4'd4, 32'hA1);
        set_eu(1, 7'd21, 4'd0, 32'hB1);
        set_eu(2, 7'd31, 4'd0, 32'hC1);
        step();
        i_eu_valid = 3'b001;
        set_eu(0, 7'd12, 4'd5, 32'hA2);
        branch_mispredict = 1'b1;
        mispredict_rob_tag = 4'd3;
        step();
        branch_mispredict = 1'b0;
        i_eu_valid = '0;
        repeat (12) step();
        check("flush_tag3_kept", 64'(seen[10]), 64'd1);
        check("flush_tag4_killed", 64'(seen[11]), 64'd0);
        check("flush_tag5_killed", 64'(seen[12]), 64'd0);
        check("flush_others", 64'(seen[20] + seen[21] + seen[30] + seen[31]), 64'd4);
        check("flush_ready", 64'(o_eu_ready), 64'h7);

        // Flush at tag 14 with wrap: 15 and 1 die, 10 survives
        do_reset();
        clear_seen();
        i_eu_valid = 3'b111;
        set_eu(0, 7'd40, 4'd10, 32'h40);
        set_eu(1, 7'd41, 4'd15, 32'h41);
        set_eu(2, 7'd42, 4'd1, 32'h42);
        step();
        i_eu_valid = '0;
        branch_mispredict = 1'b1;
        mispredict_rob_tag = 4'd14;
        step();
        branch_mispredict = 1'b0;
        repeat (8) step();
        check("wrap_tag10_kept", 64'(seen[40]), 64'd1);
        check("wrap_tag15_killed", 64'(seen[41]), 64'd0);
        check("wrap_tag1_killed", 64'(seen[42]), 64'd0);

        // Reset mid-operation discards buffered results
        i_eu_valid = 3'b111;
        set_eu(0, 7'd50, 4'd0, 32'h50);
        set_eu(1, 7'd51, 4'd0, 32'h51);
        set_eu(2, 7'd52, 4'd0, 32'h52);
        step();
        i_eu_valid = '0;
        reset = 1'b0;
        step();
        check("midrst_valid", 64'(o_cdb_valid), 64'd0);
        check("midrst_ready", 64'(o_eu_ready), 64'h7);
        clear_seen();
        reset = 1'b1;
        repeat (8) step();
        check("midrst_none", 64'(seen[50] + seen[51] + seen[52]), 64'd0);

        // Single EU2 result into empty FIFOs: latency LAT
        do_reset();
        i_eu_valid = 3'b100;
        set_eu(2, 7'd9, 4'd6, 32'h99);
        for (int s = 1; s <= 3; s++) begin
            step();
            i_eu_valid = '0;
            check("lat_valid", 64'(o_cdb_valid), 64'(s == LAT));
            if (s == LAT) check("lat_prd", 64'(o_cdb_prd), 64'd9);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
